// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: handles a cache miss by streaming one block of word reads
// to a pipelined main memory. Each returned word is steered into the data
// array, and the tag is committed together with the last word. fsm_busy
// stalls the pipeline for the whole fill.
module cache_fill_fsm #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic                     memory_data_valid,
    output logic                     fsm_busy,
    output logic                     mem_read,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     write_tag_array
);

    localparam int FW = $clog2(WORDS);
    // One extra counter bit lets the counters hold WORDS without wrapping.
    localparam int CW = FW + 1;
    localparam logic [CW-1:0]     CNT_FULL  = CW'(WORDS);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(WORDS - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]     CNT_ZERO  = CW'(0);
    // Clear the word-in-block bits and the byte-in-word bit.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((2 * WORDS) - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [CW-1:0]     r_issue_cnt;
    logic [CW-1:0]     w_issue_nxt;
    logic [CW-1:0]     r_ret_cnt;
    logic [CW-1:0]     w_ret_nxt;
    logic              w_mem_read;
    logic              w_write_data;
    logic              w_write_tag;
    logic [ADDR_W-1:0] w_offset;

    // Byte offset of the word currently being requested.
    assign w_offset = ADDR_W'({r_issue_cnt, 1'b0});

    // Next-state, counter updates and per-cycle strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_issue_nxt  = r_issue_cnt;
        w_ret_nxt    = r_ret_cnt;
        w_mem_read   = 1'b0;
        w_write_data = 1'b0;
        w_write_tag  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_state_nxt = ST_FILL;
                    w_base_nxt  = miss_address & BASE_MASK;
                    w_issue_nxt = CNT_ZERO;
                    w_ret_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                // Memory is pipelined: one request per cycle until the block is issued.
                if (r_issue_cnt < CNT_FULL) begin
                    w_mem_read  = 1'b1;
                    w_issue_nxt = r_issue_cnt + CNT_ONE;
                end else begin
                    w_mem_read  = 1'b0;
                end
                // Only returns for words already requested are accepted.
                if (memory_data_valid && (r_ret_cnt < r_issue_cnt)) begin
                    w_write_data = 1'b1;
                    w_ret_nxt    = r_ret_cnt + CNT_ONE;
                    if (r_ret_cnt == CNT_LAST) begin
                        w_write_tag = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, block base and counters; reset aborts any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_issue_cnt <= CNT_ZERO;
            r_ret_cnt   <= CNT_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_ret_cnt   <= w_ret_nxt;
        end
    end

    assign fsm_busy         = (r_state == ST_FILL);
    assign mem_read         = w_mem_read;
    assign memory_address   = w_mem_read ? (r_base + w_offset) : r_base;
    assign write_data_array = w_write_data;
    assign fill_word        = r_ret_cnt[FW-1:0];
    assign write_tag_array  = w_write_tag;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling responder between the pipeline's cache arrays and the multi-cycle main memory. On a cache miss from the IF or MEM stage, it stalls the pipeline, streams one block's worth of word reads to a pipelined memory, and steers each returned word into the cache data array. On the last word it commits the tag. The pipeline consumes `fsm_busy` as a stall source alongside the hazard unit.

## Interface
- `WORDS`, default 8: 16-bit words per cache block. Power of two, ≥2.
- `ADDR_W`, default 16: byte-address width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `miss_detected` in 1: cache lookup missed this cycle. Sampled only in IDLE.
- `miss_address` in ADDR_W: byte address of the missing access. Sampled with `miss_detected`.
- `memory_data_valid` in 1: memory returns one word this cycle, in request order.
- `fsm_busy` out 1: fill in progress. Drives the pipeline stall.
- `mem_read` out 1: read request to memory this cycle.
- `memory_address` out ADDR_W: byte address of the current request.
- `write_data_array` out 1: write `memory_data` into the data array this cycle.
- `fill_word` out log2(WORDS): word slot within the block targeted by `write_data_array`.
- `write_tag_array` out 1: commit tag/valid for the latched block this cycle.

## Operation
- Block base = `miss_address` with its low log2(WORDS)+1 bits cleared (word = 2 bytes). For the defaults, base = addr & 0xFFF0.
- State machine has two states:
  - IDLE: `miss_detected`=1 latches base, clears `issue_cnt` and `ret_cnt`, and moves to FILL next edge. Otherwise stays in IDLE.
  - FILL: exits to IDLE on the edge where the last word (`ret_cnt`=WORDS-1) returns with `memory_data_valid`=1.
- Issue side:
  - `mem_read` = FILL && `issue_cnt` < WORDS.
  - `memory_address` = base + 2·`issue_cnt` (mod 2^ADDR_W; aligned base means no wrap within a block). Value is don't-care when `mem_read`=0; drive base.
  - `issue_cnt` increments every cycle `mem_read`=1. Memory is pipelined with no backpressure.
- Return side:
  - `write_data_array` = FILL && `memory_data_valid` && (`ret_cnt` < `issue_cnt`).
  - `fill_word` = `ret_cnt`.
  - `ret_cnt` increments on each accepted return.
- `write_tag_array` = `write_data_array` && `ret_cnt`=WORDS-1, asserted in the same cycle as the final data write.
- Counters are log2(WORDS)+1 bits wide and saturate logically at WORDS. They do not wrap mid-fill.
- `fsm_busy` = (state==FILL). It is registered, so it goes high the cycle after the miss is sampled.
- Ignored events:
  - `memory_data_valid` in IDLE.
  - `memory_data_valid` with `ret_cnt`==`issue_cnt` (unsolicited).
  - `miss_detected` during FILL.
- A new miss is accepted in the first IDLE cycle after a fill.

## Timing
- Reset is asynchronous. It forces IDLE, `issue_cnt`=`ret_cnt`=0 and base=0. All outputs read 0 while `rst`=1 and afterwards, until a miss arrives.
- Reset mid-fill aborts the fill with no tag write. Returns still in flight from memory after reset are ignored, because the FSM is in IDLE.
- The miss is sampled at edge E0. Cycles 1..WORDS carry requests for words 0..WORDS-1.
- With memory latency L, the valid for word k arrives in cycle 1+k+L. The tag write happens in cycle WORDS+L, and `fsm_busy` falls at cycle WORDS+L+1.
  - For the defaults with L=4: requests in cycles 1–8, returns in cycles 5–12, tag write in cycle 12, busy low in cycle 13.
- Gaps in `memory_data_valid` stretch FILL without changing issue timing or ordering.
- A miss presented in the same cycle as the final return is ignored, since the FSM is still in FILL. The pipeline re-presents it, because a stalled access re-looks-up.

## Test plan
- Basic fill, L=4. Stimulus: `miss_address`=0x1234. Required response:
  - `memory_address` = 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - `write_data_array` in cycles 5–12 with `fill_word` 0–7.
  - `write_tag_array` only in cycle 12.
  - `fsm_busy` high in cycles 1–12, low in cycle 13.
- Irregular returns: same miss with valid gaps (valids in cycles 5, 7, 8, 11, 12, 13, 15, 16). Required: eight data writes in slot order 0–7, tag write in cycle 16 only, busy low in cycle 17.
- Spurious inputs:
  - `memory_data_valid` pulsed in IDLE → no writes and busy stays 0.
  - `miss_detected` (0x4000) pulsed during a fill of 0x1234 → no effect.
- Back-to-back misses: 0xFFFE then 0x0008, presented at the first IDLE cycle. Required addresses: 0xFFF0–0xFFFE, then 0x0000–0x000E. Each fill has exactly one tag write.
- Reset mid-fill: assert `rst` asynchronously in cycle 6 of a fill, then keep returning valids. Required: all outputs 0 immediately, no further data or tag writes, and a fresh miss afterwards fills normally.
